nzcv_flag_register: RTL and testbench

- Computes the ARM-style N, Z, C, V condition flags for the 32-bit ALU and holds them in a 4-bit status register.
- Sits beside the ALU datapath and takes the ALU opcode, both operands and the ALU result.
- The registered flags drive conditional execution.
- The current carry flag is also exported as the carry-in for ADC/SBC.

---
 rtl/nzcv_flag_register.sv | 147 ++++++++++++++
 tb/tb_nzcv_flag_register.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nzcv_flag_register.sv
// ARM-style N/Z/C/V status register for a WIDTH-bit ALU.
// N/Z come from the supplied result; C from an internal carry adder; V from operand/result sign bits.

package nzcv_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_RSB  = 4'b0010,
        OP_ADC  = 4'b0011,
        OP_SBC  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_ORR  = 4'b0110,
        OP_EOR  = 4'b0111,
        OP_BIC  = 4'b1000,
        OP_MOV  = 4'b1001,
        OP_MVN  = 4'b1010,
        OP_CMP  = 4'b1011,
        OP_CMN  = 4'b1100,
        OP_TST  = 4'b1101,
        OP_TEQ  = 4'b1110,
        OP_PASS = 4'b1111
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

module nzcv_flag_register
    import nzcv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       op_code,
    input  logic             s_flag,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] result,
    output logic [3:0]       output_flags,
    output logic [3:0]       flags_next,
    output logic             carry_out
);

    localparam int MSB = WIDTH - 1;

    alu_op_e          op;
    logic             is_compare;
    logic             upd;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic             a_sign;
    logic             b_sign;
    logic             r_sign;
    nzcv_t            cur;
    nzcv_t            nxt;
    nzcv_t            flags_d;
    nzcv_t            flags_q;

    assign op     = alu_op_e'(op_code);
    assign cur    = flags_q;
    assign a_sign = in1[MSB];
    assign b_sign = in2[MSB];
    assign r_sign = result[MSB];

    assign is_compare = (op == OP_CMP) || (op == OP_CMN) || (op == OP_TST) || (op == OP_TEQ);
    assign upd        = s_flag || is_compare;

    // Subtractions reuse the adder as a + ~b + cin so C means "no borrow".
    // NOTE: every always_comb output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        add_a   = in1;
        add_b   = in2;
        add_cin = 1'b0;
        unique case (op)
            OP_ADC: add_cin = cur.c;
            OP_SUB, OP_CMP: begin
                add_b   = ~in2;
                add_cin = 1'b1;
            end
            OP_SBC: begin
                add_b   = ~in2;
                add_cin = cur.c;
            end
            OP_RSB: begin
                add_a   = in2;
                add_b   = ~in1;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    // Logic-class ops leave C and V untouched; only arith ops replace them.
    always_comb begin
        nxt.n = r_sign;
        nxt.z = (result == '0);
        nxt.c = cur.c;
        nxt.v = cur.v;
        unique case (op)
            OP_ADD, OP_ADC, OP_CMN: begin
                nxt.c = sum[WIDTH];
                nxt.v = (a_sign == b_sign) && (r_sign != a_sign);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                nxt.c = sum[WIDTH];
                nxt.v = (a_sign != b_sign) && (r_sign != a_sign);
            end
            OP_RSB: begin
                nxt.c = sum[WIDTH];
                nxt.v = (a_sign != b_sign) && (r_sign != b_sign);
            end
            default: ;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (upd) begin
            flags_d = nxt;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_next   = nxt;
    assign output_flags = flags_q;
    assign carry_out    = flags_q.c;

endmodule

// File: tb/tb_nzcv_flag_register.sv
// Scoreboard bench for nzcv_flag_register: driver pushes model expectations, monitor pops and compares.
// The reference model derives flags from unsigned/signed arithmetic on the operands.
`timescale 1ns/1ps

module tb_nzcv_flag_register;

    localparam int WIDTH = 32;

    typedef struct {
        string      name;
        logic [3:0] nxt;
        logic [3:0] flg;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [3:0]       op_code;
    logic             s_flag;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] result;
    logic [3:0]       output_flags;
    logic [3:0]       flags_next;
    logic             carry_out;

    int         total = 0;
    int         bad   = 0;
    logic [3:0] model_flags = 4'b0000;
    exp_t       sb_q[$];

    nzcv_flag_register #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_code      (op_code),
        .s_flag       (s_flag),
        .in1          (in1),
        .in2          (in2),
        .result       (result),
        .output_flags (output_flags),
        .flags_next   (flags_next),
        .carry_out    (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic is_neg(input logic [WIDTH-1:0] x);
        return $signed(x) < 0;
    endfunction

    // Flags from the architectural meaning of each op: carry = no unsigned overflow/borrow,
    // overflow = signed result sign contradicts the operand signs.
    function automatic logic [3:0] model_next(input logic [3:0] cur, input logic [3:0] op,
                                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] r);
        longint la, lb;
        longint lim;
        logic   n, z, c, v;
        la  = longint'(a);
        lb  = longint'(b);
        lim = longint'(1) << WIDTH;
        n = is_neg(r);
        z = (r == 0);
        c = cur[1];
        v = cur[0];
        case (op)
            4'd0, 4'd12: begin
                c = (la + lb) >= lim;
                v = (is_neg(a) == is_neg(b)) && (n != is_neg(a));
            end
            4'd3: begin
                c = (la + lb + longint'(cur[1])) >= lim;
                v = (is_neg(a) == is_neg(b)) && (n != is_neg(a));
            end
            4'd1, 4'd11: begin
                c = la >= lb;
                v = (is_neg(a) != is_neg(b)) && (n != is_neg(a));
            end
            4'd4: begin
                c = la >= lb + longint'(!cur[1]);
                v = (is_neg(a) != is_neg(b)) && (n != is_neg(a));
            end
            4'd2: begin
                c = lb >= la;
                v = (is_neg(a) != is_neg(b)) && (n != is_neg(b));
            end
            default: ;
        endcase
        return {n, z, c, v};
    endfunction

    task automatic apply(input string name, input logic [3:0] op, input logic s,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] r);
        exp_t e;
        logic u;
        @(negedge clk);
        op_code = op;
        s_flag  = s;
        in1     = a;
        in2     = b;
        result  = r;
        u       = s || (op inside {4'd11, 4'd12, 4'd13, 4'd14});
        e.name  = name;
        e.nxt   = model_next(model_flags, op, a, b, r);
        e.flg   = u ? e.nxt : model_flags;
        model_flags = e.flg;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        op_code = 4'b1001;
        s_flag  = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk);
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
    endtask

    // Monitor: flags_next is checked mid-cycle, output_flags just after the following edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check({e.name, " flags_next"}, flags_next, e.nxt);
                @(posedge clk);
                #1;
                check({e.name, " output_flags"}, output_flags, e.flg);
                check({e.name, " carry_out"}, {3'b000, carry_out}, {3'b000, e.flg[1]});
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] a, b, r;
        logic [3:0]       op;
        logic [WIDTH-1:0] corner [4];
        corner[0] = '0;
        corner[1] = '1;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF;

        op_code = 4'b1001;
        s_flag  = 1'b0;
        in1     = '0;
        in2     = '0;
        result  = '0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset async", output_flags, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op_code = 4'($urandom_range(0, 10));
            s_flag  = 1'b0;
            in1     = $urandom;
            in2     = $urandom;
            result  = $urandom;
            @(posedge clk);
            #1;
            check("reset hold", output_flags, 4'b0000);
        end
        idle();

        apply("zero pass", 4'b1111, 1'b1, '0, '0, '0);
        apply("add neg+neg", 4'b0000, 1'b1, '1, '1, '1);
        apply("add pos+pos ovf", 4'b0000, 1'b1, '0, '0, '1);
        apply("sub 0-max", 4'b0001, 1'b1, '0, '1, '0);
        apply("sub max-0", 4'b0001, 1'b1, '1, '0, '1);
        apply("add no s hold", 4'b0000, 1'b0, 32'h1234, 32'h5678, '0);
        apply("cmp eq no s", 4'b1011, 1'b0, 32'd5, 32'd5, '0);
        apply("set c", 4'b0000, 1'b1, '1, '1, '1);
        apply("adc c1", 4'b0011, 1'b1, '1, '0, '0);
        apply("clear c", 4'b0001, 1'b1, '0, '1, '0);
        apply("adc c0", 4'b0011, 1'b1, '1, '0, '0);
        apply("rsb", 4'b0010, 1'b1, 32'd7, 32'd3, 32'hFFFF_FFFC);
        apply("sbc", 4'b0100, 1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFE);
        apply("tst no s", 4'b1101, 1'b0, '1, '0, '0);
        idle();
        drain();

        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : WIDTH'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       r = '0;
                1:       r = WIDTH'($urandom);
                2:       r = a - b;
                default: r = a + b;
            endcase
            apply("random", op, 1'($urandom_range(0, 1)), a, b, r);
        end
        idle();
        drain();

        // Reset in the middle of a cycle with an update pending must win.
        apply("pre reset", 4'b0000, 1'b1, '1, '1, '1);
        idle();
        drain();
        @(negedge clk);
        op_code = 4'b0000;
        s_flag  = 1'b1;
        in1     = '1;
        in2     = '1;
        result  = '1;
        #2 rst_n = 1'b0;
        #1;
        check("mid reset async", output_flags, 4'b0000);
        check("mid reset carry", {3'b000, carry_out}, 4'b0000);
        @(posedge clk);
        #1;
        check("mid reset edge", output_flags, 4'b0000);
        @(negedge clk);
        op_code = 4'b1001;
        s_flag  = 1'b0;
        rst_n   = 1'b1;
        model_flags = 4'b0000;
        @(posedge clk);
        #1;
        check("after reset release", output_flags, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
